// File: rtl/gpr_wb_queue.sv
// In-order writeback queue between the result path and the single GPR write port.
// It drains one entry per cycle and forwards the youngest pending value to two read ports.
module gpr_wb_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_rd,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       hold,
  output logic                       gpr_wen,
  output logic [ADDR_WIDTH-1:0]      gpr_waddr,
  output logic [DATA_WIDTH-1:0]      gpr_wdata,
  input  logic [ADDR_WIDTH-1:0]      q_rs1,
  input  logic [ADDR_WIDTH-1:0]      q_rs2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [DATA_WIDTH-1:0]      fwd1_data,
  output logic [DATA_WIDTH-1:0]      fwd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on occupancy, never on a same-cycle drain.
  logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         occ;
  logic                  occ_full;
  logic                  occ_empty;
  logic                  push_fire;
  logic                  store;
  logic                  pop;

  assign occ_full  = (occ == CW'(DEPTH));
  assign occ_empty = (occ == '0);

  assign in_ready  = !occ_full && !rst;
  assign push_fire = in_valid && in_ready;
  // x0 results complete the handshake but are never stored
  assign store     = push_fire && (in_rd != '0);
  assign pop       = gpr_wen;

  assign gpr_wen   = !occ_empty && !hold && !rst;
  assign gpr_waddr = (occ_empty || rst) ? '0 : rd_mem[head];
  assign gpr_wdata = (occ_empty || rst) ? '0 : data_mem[head];

  assign count = rst ? '0 : occ;
  assign empty = rst || occ_empty;
  assign full  = !rst && occ_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (store) tail <= tail + PW'(1);
      if (pop)   head <= head + PW'(1);
      case ({store, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rd_mem[tail]   <= in_rd;
      data_mem[tail] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  logic [PW-1:0] idx;
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!rst && (CW'(i) < occ)) begin
        if ((q_rs1 != '0) && (rd_mem[idx] == q_rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_mem[idx];
        end
        if ((q_rs2 != '0) && (rd_mem[idx] == q_rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Bench for gpr_wb_queue: hand-computed vector table, then random traffic
// checked against a queue-based reference model.
module tb_gpr_wb_queue;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          hold;
  logic          gpr_wen;
  logic [AW-1:0] gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic [AW-1:0] q_rs1;
  logic [AW-1:0] q_rs2;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [DW-1:0] fwd1_data;
  logic [DW-1:0] fwd2_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: pending entries packed as {rd, data}, oldest first.
  logic [AW+DW-1:0] exp_q[$];

  gpr_wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .hold(hold), .gpr_wen(gpr_wen),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data),
    .fwd2_data(fwd2_data), .count(count), .empty(empty), .full(full)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rst;
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          hold;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    int            e_cnt;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_rdy;
    logic          e_h1;
    logic [DW-1:0] e_d1;
    logic          e_h2;
    logic [DW-1:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic r, input logic v, input int rd, input logic [DW-1:0] d,
                       input logic h, input int s1, input int s2, input int cnt,
                       input logic wen, input int wa, input logic [DW-1:0] wd,
                       input logic rdy, input logic h1, input logic [DW-1:0] d1,
                       input logic h2, input logic [DW-1:0] d2);
    vec_t t;
    t.rst = r; t.valid = v; t.rd = AW'(rd); t.data = d; t.hold = h;
    t.rs1 = AW'(s1); t.rs2 = AW'(s2); t.e_cnt = cnt; t.e_wen = wen;
    t.e_waddr = AW'(wa); t.e_wdata = wd; t.e_rdy = rdy;
    t.e_h1 = h1; t.e_d1 = d1; t.e_h2 = h2; t.e_d2 = d2;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle %0d %s: got 0x%0h expected 0x%0h", cyc, name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic v, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d, input logic h,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    rst = r; in_valid = v; in_rd = rd; in_data = d; hold = h; q_rs1 = s1; q_rs2 = s2;
  endtask

  // Advance through the rising edge, updating the model from the inputs and
  // the pre-edge pending list.
  task automatic finish_cycle();
    int  sz;
    logic take;
    sz = exp_q.size();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      take = in_valid && (sz < DEPTH) && (in_rd != '0);
      if (sz > 0 && !hold) void'(exp_q.pop_front());
      if (take) exp_q.push_back({in_rd, in_data});
    end
    cyc++;
    #1;
  endtask

  // scoreboard: expected outputs derived from the pending list
  task automatic model_check();
    int               sz;
    logic [AW+DW-1:0] e;
    logic             h1, h2;
    logic [DW-1:0]    d1, d2;
    sz = exp_q.size();
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    if (!rst) begin
      for (int i = 0; i < sz; i++) begin
        e = exp_q[i];
        if (q_rs1 != '0 && e[AW+DW-1:DW] == q_rs1) begin h1 = 1'b1; d1 = e[DW-1:0]; end
        if (q_rs2 != '0 && e[AW+DW-1:DW] == q_rs2) begin h2 = 1'b1; d2 = e[DW-1:0]; end
      end
    end
    e = (!rst && sz > 0) ? exp_q[0] : '0;
    check("m_count",    DW'(count),    rst ? 0 : DW'(sz));
    check("m_empty",    DW'(empty),    DW'(rst || sz == 0));
    check("m_full",     DW'(full),     DW'(!rst && sz == DEPTH));
    check("m_in_ready", DW'(in_ready), DW'(!rst && sz < DEPTH));
    check("m_gpr_wen",  DW'(gpr_wen),  DW'(!rst && sz > 0 && !hold));
    check("m_waddr",    DW'(gpr_waddr), DW'(e[AW+DW-1:DW]));
    check("m_wdata",    gpr_wdata,     e[DW-1:0]);
    check("m_fwd1_hit", DW'(fwd1_hit), DW'(h1));
    check("m_fwd1_data", fwd1_data,    d1);
    check("m_fwd2_hit", DW'(fwd2_hit), DW'(h2));
    check("m_fwd2_data", fwd2_data,    d2);
  endtask

  initial begin
    // reset, single push, one-cycle commit
    add_v(1,0, 0,32'h0,          0, 0,0, 0,0,0,32'h0,          0, 0,32'h0, 0,32'h0);
    add_v(0,1, 5,32'hDEADBEEF,   0, 5,0, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    add_v(0,0, 0,32'h0,          0, 5,0, 1,1,5,32'hDEADBEEF,   1, 1,32'hDEADBEEF, 0,32'h0);
    add_v(0,0, 0,32'h0,          0, 5,0, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    // hold, fill, stall, release and drain in order
    add_v(0,1, 1,32'h101,        1, 0,0, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    add_v(0,1, 2,32'h102,        1, 0,0, 1,0,1,32'h101,        1, 0,32'h0, 0,32'h0);
    add_v(0,1, 3,32'h103,        1, 0,0, 2,0,1,32'h101,        1, 0,32'h0, 0,32'h0);
    add_v(0,1, 4,32'h104,        1, 0,0, 3,0,1,32'h101,        1, 0,32'h0, 0,32'h0);
    add_v(0,1, 9,32'h109,        1, 3,4, 4,0,1,32'h101,        0, 1,32'h103, 1,32'h104);
    add_v(0,1, 9,32'h109,        0, 3,4, 4,1,1,32'h101,        0, 1,32'h103, 1,32'h104);
    add_v(0,1, 9,32'h109,        0, 1,0, 3,1,2,32'h102,        1, 0,32'h0, 0,32'h0);
    add_v(0,0, 0,32'h0,          0, 9,0, 3,1,3,32'h103,        1, 1,32'h109, 0,32'h0);
    add_v(0,0, 0,32'h0,          0, 0,0, 2,1,4,32'h104,        1, 0,32'h0, 0,32'h0);
    add_v(0,0, 0,32'h0,          0, 0,0, 1,1,9,32'h109,        1, 0,32'h0, 0,32'h0);
    add_v(0,0, 0,32'h0,          0, 0,0, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    // youngest-wins forwarding, x0 discard
    add_v(0,1, 7,32'h11,         1, 7,8, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    add_v(0,1, 7,32'h22,         1, 7,8, 1,0,7,32'h11,         1, 1,32'h11, 0,32'h0);
    add_v(0,0, 0,32'h0,          1, 7,8, 2,0,7,32'h11,         1, 1,32'h22, 0,32'h0);
    add_v(0,1, 0,32'h55,         0, 0,7, 2,1,7,32'h11,         1, 0,32'h0, 1,32'h22);
    add_v(0,0, 0,32'h0,          0, 0,7, 1,1,7,32'h22,         1, 0,32'h0, 1,32'h22);
    add_v(0,0, 0,32'h0,          0, 0,7, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    // reset mid-operation discards pending entries
    add_v(0,1,10,32'hA,          1,10,0, 0,0,0,32'h0,          1, 0,32'h0, 0,32'h0);
    add_v(0,1,11,32'hB,          1,10,0, 1,0,10,32'hA,         1, 1,32'hA, 0,32'h0);
    add_v(0,1,12,32'hC,          1,10,12, 2,0,10,32'hA,        1, 1,32'hA, 0,32'h0);
    add_v(1,0, 0,32'h0,          0,10,12, 0,0,0,32'h0,         0, 0,32'h0, 0,32'h0);
    add_v(0,0, 0,32'h0,          0,10,12, 0,0,0,32'h0,         1, 0,32'h0, 0,32'h0);
    add_v(0,0, 0,32'h0,          0,11,12, 0,0,0,32'h0,         1, 0,32'h0, 0,32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].rd, vecs[i].data, vecs[i].hold,
            vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      check("count",     DW'(count),    DW'(vecs[i].e_cnt));
      check("empty",     DW'(empty),    DW'(vecs[i].rst || vecs[i].e_cnt == 0));
      check("full",      DW'(full),     DW'(vecs[i].e_cnt == DEPTH));
      check("in_ready",  DW'(in_ready), DW'(vecs[i].e_rdy));
      check("gpr_wen",   DW'(gpr_wen),  DW'(vecs[i].e_wen));
      check("gpr_waddr", DW'(gpr_waddr), DW'(vecs[i].e_waddr));
      check("gpr_wdata", gpr_wdata,     vecs[i].e_wdata);
      check("fwd1_hit",  DW'(fwd1_hit), DW'(vecs[i].e_h1));
      check("fwd1_data", fwd1_data,     vecs[i].e_d1);
      check("fwd2_hit",  DW'(fwd2_hit), DW'(vecs[i].e_h2));
      check("fwd2_data", fwd2_data,     vecs[i].e_d2);
      finish_cycle();
    end

    // model-checked: reset, prefill two, then 10 cycles of back-to-back push/pop
    drive(1, 0, '0, '0, 0, '0, '0);
    @(negedge clk); model_check(); finish_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, AW'(20 + i), $urandom, 1, AW'(20), AW'(21));
      @(negedge clk); model_check(); finish_cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, AW'(1 + i), $urandom, 0, AW'(1 + i), AW'(i));
      @(negedge clk); model_check(); check("steady_count", DW'(count), 2); finish_cycle();
    end

    // randomized traffic with a narrow index range to force collisions
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)));
      @(negedge clk); model_check(); finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
